// File: rtl/dram_pkg.sv
// Shared definitions for the per-core DRAM burst master: default widths,
// response FIFO depth and the burst FSM state encoding.
package dram_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 4;
  localparam int RSP_DEPTH  = 4;
  localparam int RSP_CNT_W  = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/dram_rsp_fifo.sv
// Small response FIFO holding {last, data} read beats between the DRAM port
// and the consumer; the head entry is presented combinationally.
module dram_rsp_fifo
  import dram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_W:0]      push_data,
  input  logic                 pop,
  output logic [DATA_W:0]      pop_data,
  output logic [RSP_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic [DATA_W:0]  mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Storage is cleared on reset so the read data bus reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + RSP_CNT_W'(push) - RSP_CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dram_burst_master.sv
// Core-side burst initiator for one DRAM port: expands a burst command into
// per-word port cycles and streams write/read beats with valid/ready.
module dram_burst_master
  import dram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t                 state;
  logic [ADDR_W-1:0]      cur_addr;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   issue_done;
  logic                   iss_v;
  logic                   iss_last;
  logic                   dram_v;
  logic                   dram_last;
  logic [RSP_CNT_W-1:0]   fifo_count;
  logic [DATA_W:0]        fifo_head;
  logic [RSP_CNT_W:0]     occupancy;
  logic                   issue_ok;
  logic                   rd_fire;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign done      = (state == DONE);

  assign rd_valid  = (fifo_count != '0);
  assign rd_fire   = rd_valid && rd_ready;
  assign rd_data   = fifo_head[DATA_W-1:0];
  assign rd_last   = rd_valid && fifo_head[DATA_W];

  // Beats already in the DRAM pipeline reserve a FIFO slot, so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_count} + (RSP_CNT_W+1)'(iss_v) + (RSP_CNT_W+1)'(dram_v);
  assign issue_ok  = (state == READ) && !issue_done && (occupancy < (RSP_CNT_W+1)'(RSP_DEPTH));

  dram_rsp_fifo #(
    .DATA_W(DATA_W)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (dram_v),
    .push_data({dram_last, mem_data_out}),
    .pop      (rd_fire),
    .pop_data (fifo_head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_addr     <= '0;
      beat_cnt     <= '0;
      issue_done   <= 1'b0;
      iss_v        <= 1'b0;
      iss_last     <= 1'b0;
      dram_v       <= 1'b0;
      dram_last    <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
    end else begin
      iss_v        <= 1'b0;
      mem_write_en <= 1'b0;
      dram_v       <= iss_v;
      dram_last    <= iss_last;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr   <= cmd_addr;
            beat_cnt   <= cmd_len;
            issue_done <= 1'b0;
            state      <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            mem_write_en <= 1'b1;
            mem_addr     <= cur_addr;
            mem_data_in  <= wr_data;
            cur_addr     <= cur_addr + 1'b1;
            if (beat_cnt == '0) begin
              state <= DONE;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        READ: begin
          if (issue_ok) begin
            mem_addr <= cur_addr;
            iss_v    <= 1'b1;
            iss_last <= (beat_cnt == '0);
            cur_addr <= cur_addr + 1'b1;
            if (beat_cnt == '0) begin
              issue_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
          // The burst ends when the consumer takes the beat tagged last.
          if (rd_fire && fifo_head[DATA_W]) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_master.sv
// Scoreboard bench for dram_burst_master with a 1-cycle registered DRAM port model.
module tb_dram_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        mem_write_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out = '0;

  logic [15:0] dram [65536];
  logic [15:0] shadow [int];
  logic [31:0] exp_wr [$];
  logic [16:0] exp_rd [$];

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int bursts = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  dram_burst_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .done        (done),
    .mem_write_en(mem_write_en),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // DRAM port model: writes commit on the edge, reads return the old word one cycle later.
  always @(posedge clk) begin
    if (mem_write_en) dram[mem_addr] <= mem_data_in;
    mem_data_out <= dram[mem_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // Scoreboard monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_write_en) begin
        if (exp_wr.size() == 0) begin
          check_output("unexpected_write", {mem_addr, mem_data_in}, 32'h0);
        end else begin
          check_output("mem_write", {mem_addr, mem_data_in}, exp_wr.pop_front());
        end
      end
      if (done) done_pulses++;
      if (prev_stall && rd_valid) begin
        check_output("rd_hold", {15'h0, rd_last, rd_data}, {15'h0, prev_last, prev_data});
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          check_output("unexpected_rd", {15'h0, rd_last, rd_data}, 32'h0);
        end else begin
          check_output("rd_beat", {15'h0, rd_last, rd_data}, {15'h0, exp_rd.pop_front()});
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
    end
  end

  task automatic check_reset_state();
    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_wr_ready", wr_ready, 0);
    check_output("rst_rd_valid", rd_valid, 0);
    check_output("rst_rd_last", rd_last, 0);
    check_output("rst_done", done, 0);
    check_output("rst_mem_we", mem_write_en, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_mem_din", mem_data_in, 0);
  endtask

  task automatic apply_stimulus(input logic wr, input logic [15:0] addr, input logic [3:0] len);
    int waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [15:0] addr, input int len, input logic [15:0] d0,
                             input int delay);
    for (int i = 0; i <= len; i++) begin
      logic [15:0] a = addr + 16'(i);
      logic [15:0] d = d0 + 16'(i);
      exp_wr.push_back({a, d});
      shadow[int'(a)] = d;
    end
    apply_stimulus(1'b1, addr, 4'(len));
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
      check_output("idle_write_en", mem_write_en, 0);
    end
    for (int i = 0; i <= len; i++) begin
      wr_valid = 1'b1;
      wr_data  = d0 + 16'(i);
      check_output("wr_ready", wr_ready, 1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check_output("wr_done", done, 1);
    check_output("wr_cmd_busy", cmd_ready, 0);
    @(posedge clk); #1;
    check_output("wr_done_end", done, 0);
    check_output("wr_cmd_ready", cmd_ready, 1);
    bursts++;
    check_output("done_pulses", done_pulses, bursts);
    check_output("wr_queue_empty", exp_wr.size(), 0);
  endtask

  task automatic read_burst(input logic [15:0] addr, input int len, input logic toggle,
                            input logic lat);
    logic got = 1'b0;
    for (int i = 0; i <= len; i++) begin
      logic [15:0] a = addr + 16'(i);
      exp_rd.push_back({(i == len), exp_word(a)});
    end
    rd_ready = 1'b1;
    apply_stimulus(1'b0, addr, 4'(len));
    if (lat) begin
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        check_output($sformatf("rd_valid_cyc%0d", k), rd_valid, (k >= 3) ? 1 : 0);
      end
    end
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (toggle) rd_ready = ~rd_ready;
    end
    check_output("rd_done_seen", got, 1);
    check_output("rd_queue_empty", exp_rd.size(), 0);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    check_output("rd_cmd_ready", cmd_ready, 1);
    bursts++;
    check_output("done_pulses", done_pulses, bursts);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) dram[i] = 16'(i) ^ 16'h5A5A;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] write burst 0x0010 len 3");
    write_burst(16'h0010, 3, 16'h00A1, 0);

    $display("[TB] read back 0x0010 len 3 with latency check");
    read_burst(16'h0010, 3, 1'b0, 1'b1);

    $display("[TB] read 0x0100 len 15 with rd_ready toggling");
    read_burst(16'h0100, 15, 1'b1, 1'b0);

    $display("[TB] write wrap at 0xFFFE len 2");
    write_burst(16'hFFFE, 2, 16'h0B01, 0);

    $display("[TB] single-beat write with delayed wr_valid");
    write_burst(16'h0040, 0, 16'h5C5C, 5);

    $display("[TB] reset during read burst");
    for (int i = 0; i < 16; i++) exp_rd.push_back({(i == 15), exp_word(16'h0200 + 16'(i))});
    rd_ready = 1'b1;
    apply_stimulus(1'b0, 16'h0200, 4'd15);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_rd.delete();
    #1;
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_burst(16'h0010, 3, 1'b0, 1'b1);
    read_burst(16'hFFFE, 2, 1'b0, 1'b0);
    read_burst(16'h0040, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
